// File: rtl/icache_refill_router.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill_router
// Routes iCache line misses to the boot ROM or the memory path and returns
// refill beats to the core, discarding stale responses after a flush.
// Rev     : 1.0
// ============================================================================
module icache_refill_router #(
  parameter int                 PADDR_W    = 40,
  parameter int                 LINE_W     = 512,
  parameter int                 NUM_BEATS  = 4,
  parameter int                 ROM_DATA_W = 128,
  parameter int                 ROM_ADDR_W = 24,
  parameter logic [PADDR_W-1:0] ROM_BASE   = 'h0,
  parameter logic [PADDR_W-1:0] ROM_SIZE   = 'h10000,
  localparam int                BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  input  logic [PADDR_W-1:0]    req_paddr_i,
  output logic                  req_ready_o,
  input  logic                  kill_i,
  output logic                  rom_req_valid_o,
  output logic [ROM_ADDR_W-1:0] rom_req_addr_o,
  input  logic                  rom_resp_valid_i,
  input  logic [ROM_DATA_W-1:0] rom_resp_data_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [PADDR_W-1:0]    mem_req_paddr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [LINE_W-1:0]     mem_resp_data_i,
  output logic                  resp_valid_o,
  output logic [LINE_W-1:0]     resp_data_o,
  output logic [BEAT_W-1:0]     resp_beat_o
);

  localparam int                 c_cnt_w     = $clog2(NUM_BEATS + 1);
  localparam logic [c_cnt_w-1:0] c_num_beats = c_cnt_w'(NUM_BEATS);
  localparam logic [BEAT_W-1:0]  c_last_beat = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ROM_WAIT = 2'd1,
    ST_MEM_REQ  = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_ghost, w_ghost_nxt;
  logic                 r_rom_stale, w_rom_stale_nxt;
  logic [c_cnt_w-1:0]   r_drain_cnt, w_drain_nxt;
  logic [BEAT_W-1:0]    r_beat, w_beat_nxt;
  logic [PADDR_W-1:0]   r_paddr;
  logic [ROM_ADDR_W-1:0] r_rom_addr;
  logic                 r_rom_pulse;
  logic                 r_resp_valid;
  logic [LINE_W-1:0]    r_resp_data;
  logic [BEAT_W-1:0]    r_resp_beat;
  logic                 w_accept;
  logic                 w_in_window;
  logic                 w_fwd_rom;
  logic                 w_fwd_mem;
  logic [PADDR_W:0]     w_off;

  // Offset from the window base at one extra bit: a set MSB means below the base.
  assign w_off       = {1'b0, req_paddr_i} - {1'b0, ROM_BASE};
  assign w_in_window = !w_off[PADDR_W] && (w_off < {1'b0, ROM_SIZE});

  assign req_ready_o = (r_state == ST_IDLE) && (r_drain_cnt == '0) && !r_rom_stale && !kill_i;
  assign w_accept    = req_valid_i && req_ready_o;

  always_comb begin
    w_state_nxt     = r_state;
    w_ghost_nxt     = r_ghost;
    w_rom_stale_nxt = r_rom_stale;
    w_drain_nxt     = r_drain_cnt;
    w_beat_nxt      = r_beat;
    w_fwd_rom       = 1'b0;
    w_fwd_mem       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ghost_nxt = 1'b0;
        if (mem_resp_valid_i && (r_drain_cnt != '0)) w_drain_nxt = r_drain_cnt - 1'b1;
        if (rom_resp_valid_i) w_rom_stale_nxt = 1'b0;
        if (w_accept) w_state_nxt = w_in_window ? ST_ROM_WAIT : ST_MEM_REQ;
      end
      ST_ROM_WAIT: begin
        if (kill_i) begin
          w_state_nxt     = ST_IDLE;
          w_rom_stale_nxt = !rom_resp_valid_i;
        end else if (rom_resp_valid_i) begin
          w_fwd_rom   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MEM_REQ: begin
        // A killed request still completes its handshake, then its beats drain.
        if (mem_req_ready_i) begin
          if (r_ghost || kill_i) begin
            w_drain_nxt = c_num_beats;
            w_ghost_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_beat_nxt  = '0;
            w_state_nxt = ST_MEM_WAIT;
          end
        end else if (kill_i) begin
          w_ghost_nxt = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (kill_i) begin
          w_drain_nxt = c_num_beats - (c_cnt_w'(r_beat) + c_cnt_w'(mem_resp_valid_i));
          w_state_nxt = ST_IDLE;
        end else if (mem_resp_valid_i) begin
          w_fwd_mem = 1'b1;
          if (r_beat == c_last_beat) w_state_nxt = ST_IDLE;
          else                       w_beat_nxt  = r_beat + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_IDLE;
      r_ghost      <= 1'b0;
      r_rom_stale  <= 1'b0;
      r_drain_cnt  <= '0;
      r_beat       <= '0;
      r_paddr      <= '0;
      r_rom_addr   <= '0;
      r_rom_pulse  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_beat  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ghost      <= w_ghost_nxt;
      r_rom_stale  <= w_rom_stale_nxt;
      r_drain_cnt  <= w_drain_nxt;
      r_beat       <= w_beat_nxt;
      r_rom_pulse  <= w_accept && w_in_window;
      r_resp_valid <= w_fwd_rom || w_fwd_mem;
      if (w_accept) begin
        r_paddr    <= req_paddr_i;
        r_rom_addr <= w_off[ROM_ADDR_W-1:0];
      end
      if (w_fwd_rom) begin
        r_resp_data <= LINE_W'(rom_resp_data_i);
        r_resp_beat <= '0;
      end else if (w_fwd_mem) begin
        r_resp_data <= mem_resp_data_i;
        r_resp_beat <= r_beat;
      end
    end
  end

  assign rom_req_valid_o = r_rom_pulse;
  assign rom_req_addr_o  = r_rom_addr;
  assign mem_req_valid_o = (r_state == ST_MEM_REQ);
  assign mem_req_paddr_o = r_paddr;
  assign resp_valid_o    = r_resp_valid;
  assign resp_data_o     = r_resp_data;
  assign resp_beat_o     = r_resp_beat;

endmodule
`default_nettype wire

// File: tb/tb_icache_refill_router.sv
`default_nettype none
// ============================================================================
// Module  : tb_icache_refill_router
// Directed and randomized checks of icache_refill_router against a
// transaction-level model of outstanding refills and discarded responses.
// Rev     : 1.0
// ============================================================================
module tb_icache_refill_router;

  localparam int              PADDR_W    = 40;
  localparam int              LINE_W     = 512;
  localparam int              NUM_BEATS  = 4;
  localparam int              BEAT_W     = 2;
  localparam int              ROM_DATA_W = 128;
  localparam int              ROM_ADDR_W = 24;
  localparam longint unsigned ROM_BASE   = 64'h0;
  localparam longint unsigned ROM_SIZE   = 64'h10000;

  logic                  clk;
  logic                  rstn;
  logic                  req_valid_i;
  logic [PADDR_W-1:0]    req_paddr_i;
  logic                  req_ready_o;
  logic                  kill_i;
  logic                  rom_req_valid_o;
  logic [ROM_ADDR_W-1:0] rom_req_addr_o;
  logic                  rom_resp_valid_i;
  logic [ROM_DATA_W-1:0] rom_resp_data_i;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic [PADDR_W-1:0]    mem_req_paddr_o;
  logic                  mem_resp_valid_i;
  logic [LINE_W-1:0]     mem_resp_data_i;
  logic                  resp_valid_o;
  logic [LINE_W-1:0]     resp_data_o;
  logic [BEAT_W-1:0]     resp_beat_o;

  icache_refill_router #(
    .PADDR_W   (PADDR_W),
    .LINE_W    (LINE_W),
    .NUM_BEATS (NUM_BEATS),
    .ROM_DATA_W(ROM_DATA_W),
    .ROM_ADDR_W(ROM_ADDR_W),
    .ROM_BASE  (PADDR_W'(ROM_BASE)),
    .ROM_SIZE  (PADDR_W'(ROM_SIZE))
  ) dut (
    .clk_i           (clk),
    .rstn_i          (rstn),
    .req_valid_i     (req_valid_i),
    .req_paddr_i     (req_paddr_i),
    .req_ready_o     (req_ready_o),
    .kill_i          (kill_i),
    .rom_req_valid_o (rom_req_valid_o),
    .rom_req_addr_o  (rom_req_addr_o),
    .rom_resp_valid_i(rom_resp_valid_i),
    .rom_resp_data_i (rom_resp_data_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_paddr_o (mem_req_paddr_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i (mem_resp_data_i),
    .resp_valid_o    (resp_valid_o),
    .resp_data_o     (resp_data_o),
    .resp_beat_o     (resp_beat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Model: what is outstanding and how many responses must still be swallowed.
  bit                    m_rom_out;
  bit                    m_mreq;
  bit                    m_ghost;
  bit                    m_rstale;
  bit                    m_pulse;
  int                    m_left;
  int                    m_next;
  int                    m_mdrop;
  logic [PADDR_W-1:0]    m_paddr;
  logic [ROM_ADDR_W-1:0] m_rom_addr;

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [PADDR_W-1:0] a);
    longint unsigned x;
    x = 64'(a);
    return (x - ROM_BASE) < ROM_SIZE;
  endfunction

  function automatic logic [LINE_W-1:0] rnd_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    m_rom_out = 0; m_mreq = 0; m_ghost = 0; m_rstale = 0; m_pulse = 0;
    m_left = 0; m_next = 0; m_mdrop = 0; m_paddr = '0; m_rom_addr = '0;
  endtask

  task automatic set_in(input bit rv, input logic [PADDR_W-1:0] a, input bit k,
                        input bit romv, input bit rdy, input bit memv);
    req_valid_i      = rv;
    req_paddr_i      = a;
    kill_i           = k;
    rom_resp_valid_i = romv;
    rom_resp_data_i  = ROM_DATA_W'(rnd_line());
    mem_req_ready_i  = rdy;
    mem_resp_valid_i = memv;
    mem_resp_data_i  = rnd_line();
  endtask

  task automatic reset_check();
    chk("rst_req_ready", LINE_W'(req_ready_o), LINE_W'(1'b1));
    chk("rst_rom_req_valid", LINE_W'(rom_req_valid_o), '0);
    chk("rst_rom_req_addr", LINE_W'(rom_req_addr_o), '0);
    chk("rst_mem_req_valid", LINE_W'(mem_req_valid_o), '0);
    chk("rst_mem_req_paddr", LINE_W'(mem_req_paddr_o), '0);
    chk("rst_resp_valid", LINE_W'(resp_valid_o), '0);
    chk("rst_resp_data", resp_data_o, '0);
    chk("rst_resp_beat", LINE_W'(resp_beat_o), '0);
  endtask

  // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic cycle();
    bit                exp_ready;
    bit                exp_v;
    bit                acc;
    int                exp_beat;
    logic [LINE_W-1:0] exp_data;
    #1;
    exp_ready = !m_rom_out && !m_mreq && m_left == 0 && m_mdrop == 0 && !m_rstale && !kill_i;
    chk("req_ready", LINE_W'(req_ready_o), LINE_W'(exp_ready));
    chk("mem_req_valid", LINE_W'(mem_req_valid_o), LINE_W'(m_mreq));
    if (m_mreq) chk("mem_req_paddr", LINE_W'(mem_req_paddr_o), LINE_W'(m_paddr));
    chk("rom_req_valid", LINE_W'(rom_req_valid_o), LINE_W'(m_pulse));
    if (m_pulse) chk("rom_req_addr", LINE_W'(rom_req_addr_o), LINE_W'(m_rom_addr));
    m_pulse  = 0;
    exp_v    = 0;
    exp_beat = 0;
    exp_data = '0;
    acc      = req_valid_i && exp_ready;
    if (kill_i) begin
      if (m_rom_out) begin
        m_rom_out = 0;
        m_rstale  = !rom_resp_valid_i;
      end else if (m_mreq) begin
        if (mem_req_ready_i) begin m_mreq = 0; m_ghost = 0; m_mdrop = NUM_BEATS; end
        else m_ghost = 1;
      end else if (m_left > 0) begin
        m_mdrop = m_left - (mem_resp_valid_i ? 1 : 0);
        m_left  = 0;
      end else begin
        if (mem_resp_valid_i && m_mdrop > 0) m_mdrop--;
        if (rom_resp_valid_i) m_rstale = 0;
      end
    end else begin
      if (m_rom_out && rom_resp_valid_i) begin
        exp_v = 1; exp_data = LINE_W'(rom_resp_data_i); exp_beat = 0; m_rom_out = 0;
      end else if (rom_resp_valid_i) begin
        m_rstale = 0;
      end
      if (m_mreq) begin
        if (mem_req_ready_i) begin
          m_mreq = 0;
          if (m_ghost) begin m_ghost = 0; m_mdrop = NUM_BEATS; end
          else begin m_left = NUM_BEATS; m_next = 0; end
        end
      end else if (m_left > 0) begin
        if (mem_resp_valid_i) begin
          exp_v = 1; exp_data = mem_resp_data_i; exp_beat = m_next; m_next++; m_left--;
        end
      end else if (m_mdrop > 0 && mem_resp_valid_i) begin
        m_mdrop--;
      end
      if (acc) begin
        m_paddr = req_paddr_i;
        if (in_win(req_paddr_i)) begin
          m_rom_out  = 1;
          m_pulse    = 1;
          m_rom_addr = ROM_ADDR_W'(req_paddr_i - PADDR_W'(ROM_BASE));
        end else begin
          m_mreq = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("resp_valid", LINE_W'(resp_valid_o), LINE_W'(exp_v));
    if (exp_v) begin
      chk("resp_data", resp_data_o, exp_data);
      chk("resp_beat", LINE_W'(resp_beat_o), LINE_W'(exp_beat));
    end
  endtask

  task automatic idle(input int n);
    set_in(0, '0, 0, 0, 0, 0);
    repeat (n) cycle();
  endtask

  task automatic req(input logic [PADDR_W-1:0] a);
    set_in(1, a, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic beat();
    set_in(0, '0, 0, 0, 0, 1);
    cycle();
  endtask

  task automatic rom_resp();
    set_in(0, '0, 0, 1, 0, 0);
    cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b0;
    set_in(0, '0, 0, 0, 0, 0);
    model_reset();
    #3;
    reset_check();
    @(posedge clk); @(posedge clk);
    #4 rstn = 1'b1;
    @(posedge clk); #1;

    // ROM hit with a recognisable pattern, answered two cycles after the pulse
    req(40'h100);
    idle(2);
    set_in(0, '0, 0, 1, 0, 0);
    rom_resp_data_i = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    cycle();
    idle(1);

    // Memory miss with a slow handshake and gapped beats
    req(40'h80_0000_0040);
    idle(3);
    set_in(0, '0, 0, 0, 1, 0); cycle();
    for (int b = 0; b < NUM_BEATS; b++) begin beat(); idle(1); end

    // Kill during MEM_WAIT after the first beat
    req(40'h12_3456_7880);
    set_in(0, '0, 0, 0, 1, 0); cycle();
    beat();
    set_in(0, '0, 1, 0, 0, 0); cycle();
    for (int b = 0; b < 3; b++) begin beat(); idle(1); end

    // Kill during MEM_REQ, then a ROM request
    req(40'h55_0000_1000);
    set_in(0, '0, 1, 0, 0, 0); cycle();
    idle(2);
    set_in(0, '0, 0, 0, 1, 0); cycle();
    for (int b = 0; b < NUM_BEATS; b++) begin beat(); idle(1); end
    req(40'h200);
    idle(1);
    rom_resp();
    idle(1);

    // Kill during ROM_WAIT, stale response, then a fresh ROM request
    req(40'h300);
    set_in(0, '0, 1, 0, 0, 0); cycle();
    idle(1);
    rom_resp();
    idle(1);
    req(40'h340);
    idle(1);
    rom_resp();
    idle(1);

    // Kill coincident with a request blocks acceptance
    set_in(1, 40'h400, 1, 0, 0, 0); cycle();
    idle(2);

    // Window boundary
    req(PADDR_W'(ROM_BASE + ROM_SIZE - 4));
    idle(1);
    rom_resp();
    idle(1);
    req(PADDR_W'(ROM_BASE + ROM_SIZE));
    set_in(0, '0, 0, 0, 1, 0); cycle();
    for (int b = 0; b < NUM_BEATS; b++) beat();
    idle(1);

    // Asynchronous reset in the middle of MEM_WAIT
    req(40'h20_0000_0000);
    set_in(0, '0, 0, 0, 1, 0); cycle();
    beat();
    set_in(0, '0, 0, 0, 0, 1);
    #2 rstn = 1'b0;
    #1;
    model_reset();
    reset_check();
    @(posedge clk); #1;
    set_in(0, '0, 0, 0, 0, 0);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    beat();
    beat();
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [PADDR_W-1:0] a;
      case ($urandom_range(0, 3))
        0:       a = PADDR_W'(ROM_BASE) + PADDR_W'({$urandom_range(0, 'h3FFF), 2'b00});
        1:       a = ($urandom_range(0, 1) == 1) ? PADDR_W'(ROM_BASE + ROM_SIZE - 4)
                                                 : PADDR_W'(ROM_BASE + ROM_SIZE);
        default: a = PADDR_W'({$urandom, $urandom});
      endcase
      set_in($urandom_range(0, 1) == 1, a, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) < 4);
      cycle();
    end
    idle(NUM_BEATS + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
